// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO (fifo_sync / fifo_mem).
// The FIFO_FWFT_EN macro selects first-word fall-through reads in both users of this package.
package fifo_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_ADDRESS = 4;
    localparam int DEFAULT_DEPTH   = 2 ** DEFAULT_ADDRESS;

    // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than an address.
    function automatic int count_width(input int address);
        return address + 1;
    endfunction

    localparam int DEFAULT_COUNT_W = count_width(DEFAULT_ADDRESS);

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_sync: one write port and one read port.
// Read port is combinational with FIFO_FWFT_EN defined, registered (reset to 0) otherwise.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int ADDRESS = DEFAULT_ADDRESS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDRESS-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [ADDRESS-1:0] rd_addr,
    output logic [WIDTH-1:0]   rd_data
);

    // Contents are deliberately left out of reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    logic unused_rd_ctrl;

    assign unused_rd_ctrl = rst ^ rd_en;
    assign rd_data        = mem_q[rd_addr];
`else
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with wrap-bit pointers, registered count and error pulses.
// Define FIFO_FWFT_EN for first-word fall-through; default is a registered one-cycle read.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDRESS  = DEFAULT_ADDRESS,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic               rd_valid,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [ADDRESS:0]   count,
    output logic               wr_er,
    output logic               rd_er
);

    localparam int CNT_W = count_width(ADDRESS);
    localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_er_q,  wr_er_d;
    logic             rd_er_q,  rd_er_d;
    logic             wr_acc;
    logic             rd_acc;

    // Request semantics: wr_en/rd_en are sampled at the rising edge; a request
    // is accepted iff the FIFO is not full/empty at that edge, otherwise it is
    // dropped and flagged on wr_er/rd_er for exactly the following cycle.
    assign full  = (wr_ptr_q[ADDRESS-1:0] == rd_ptr_q[ADDRESS-1:0]) &&
                   (wr_ptr_q[ADDRESS] != rd_ptr_q[ADDRESS]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_er_d  = wr_en && !wr_acc;
        rd_er_d  = rd_en && !rd_acc;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_er_q  <= 1'b0;
            rd_er_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_er_q  <= wr_er_d;
            rd_er_q  <= rd_er_d;
        end
    end

    assign count        = count_q;
    assign wr_er        = wr_er_q;
    assign rd_er        = rd_er_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    // Reset must not let a same-cycle request touch storage or the read register.
    fifo_mem #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDRESS (ADDRESS)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_q[ADDRESS-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr_q[ADDRESS-1:0]),
        .rd_data (rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign rd_valid = !empty;
`else
    logic rd_valid_q;
    logic rd_valid_d;

    assign rd_valid_d = rd_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync (WIDTH=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2) with a queue-based model.
// Honours FIFO_FWFT_EN for the read-side expectations.
module tb_fifo_sync;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [4:0]   count;
    logic         wr_er;
    logic         rd_er;

    fifo_sync #(
        .WIDTH    (8),
        .DEPTH    (16),
        .ADDRESS  (4),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_er        (wr_er),
        .rd_er        (rd_er)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    bit           check_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rd_data = '0;
    bit           exp_rd_valid = 1'b0;
    bit           exp_wr_er = 1'b0;
    bit           exp_rd_er = 1'b0;
    bit           m_rd;
    bit           m_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: occupancy is the queue length; accept/reject decided from the pre-edge queue.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_rd_data  = '0;
            exp_rd_valid = 1'b0;
            exp_wr_er    = 1'b0;
            exp_rd_er    = 1'b0;
        end else begin
            m_rd = rd_en && (exp_q.size() != 0);
            m_wr = wr_en && (exp_q.size() != DEPTH);
            exp_rd_valid = m_rd;
            if (m_rd) exp_rd_data = exp_q.pop_front();
            if (m_wr) exp_q.push_back(wr_data);
            exp_wr_er = wr_en && !m_wr;
            exp_rd_er = rd_en && !m_rd;
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_count", count, exp_q.size());
            chk("cyc_full", full, exp_q.size() == DEPTH);
            chk("cyc_empty", empty, exp_q.size() == 0);
            chk("cyc_almost_full", almost_full, exp_q.size() >= 14);
            chk("cyc_almost_empty", almost_empty, exp_q.size() <= 2);
            chk("cyc_wr_er", wr_er, exp_wr_er);
            chk("cyc_rd_er", rd_er, exp_rd_er);
`ifdef FIFO_FWFT_EN
            chk("cyc_rd_valid", rd_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("cyc_rd_data", rd_data, exp_q[0]);
`else
            chk("cyc_rd_valid", rd_valid, exp_rd_valid);
            chk("cyc_rd_data", rd_data, exp_rd_data);
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit w, input logic [W-1:0] d, input bit rd);
        @(negedge clk);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_en = 1'b1;

        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_almost_empty", almost_empty, 1);
        chk("reset_almost_full", almost_full, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_wr_er", wr_er, 0);

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, W'(i), 1'b0);
            chk("fill_count", count, i);
            if (i == 13) chk("af_below", almost_full, 0);
            if (i == 14) chk("af_at_level", almost_full, 1);
        end
        chk("fill_full", full, 1);

        // Write while full is rejected.
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        chk("full_wr_er", wr_er, 1);
        chk("full_count", count, 16);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_wr_er_pulse", wr_er, 0);

        // Both requests while full: read wins.
        step(1'b0, 1'b1, 8'hBB, 1'b1);
        chk("full_both_count", count, 15);
        chk("full_both_wr_er", wr_er, 1);
`ifndef FIFO_FWFT_EN
        chk("full_both_rd_data", rd_data, 8'h01);
        chk("full_both_rd_valid", rd_valid, 1);
`endif

        for (int i = 2; i <= 16; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
            chk("drain_rd_data", rd_data, i);
`endif
        end
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);

        // Read while empty is rejected.
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("empty_rd_er", rd_er, 1);
        chk("empty_rd_valid", rd_valid, 0);
`ifndef FIFO_FWFT_EN
        chk("empty_rd_data_hold", rd_data, 8'h10);
`endif
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("empty_rd_er_pulse", rd_er, 0);

        // Both requests while empty: write wins, no bypass.
        step(1'b0, 1'b1, 8'h55, 1'b1);
        chk("empty_both_count", count, 1);
        chk("empty_both_rd_er", rd_er, 1);
        chk("empty_both_rd_valid", rd_valid, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("empty_both_word", rd_data, 8'h55);
`endif
        chk("empty_both_drained", count, 0);

        // Stream at count=8 through pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, W'(8'h20 + i), 1'b0);
        chk("stream_prefill", count, 8);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, W'(8'h30 + i), 1'b1);
            chk("stream_count", count, 8);
`ifndef FIFO_FWFT_EN
            chk("stream_rd_data", rd_data, (i < 8) ? (8'h20 + i) : (8'h30 + i - 8));
`endif
        end

        // Reset mid-stream at count=5, with requests pending.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_rst_count", count, 5);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rd_valid", rd_valid, 0);
`ifdef FIFO_FWFT_EN
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk("fwft_rd_valid", rd_valid, 1);
        chk("fwft_rd_data", rd_data, 8'h77);
`else
        chk("rst_rd_data", rd_data, 0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_rd_valid", rd_valid, 1);
        chk("post_rst_rd_data", rd_data, 8'h77);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_rd_valid_pulse", rd_valid, 0);
`endif

        step(1'b0, 1'b0, 8'h00, 1'b0);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
